// File: rtl/bin_pkg.sv
// bin_pkg: shared state encoding, colour constants and widths for bin_unpack
package bin_pkg;
  localparam int PIX_W = 24;
  localparam int CNT_W = 12;
  localparam logic [PIX_W-1:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [PIX_W-1:0] RGB_BLACK = 24'h000000;
  typedef logic [1:0] state_t;
  localparam state_t S_EMPTY = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_PAD   = 2'd2;
endpackage

// File: rtl/bin_unpack_buf.sv
// bin_unpack_buf: current shift register plus one prefetch byte with s_ready handshake
module bin_unpack_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       pf_take,
  input  logic [7:0] cur_data_d,
  input  logic [3:0] cur_cnt_d,
  output logic [7:0] cur_data,
  output logic [3:0] cur_cnt,
  output logic [7:0] pf_data,
  output logic       pf_full
);
  logic accept;
  assign s_ready = !pf_full;
  assign accept = s_valid && s_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_data <= '0;
      cur_cnt <= '0;
      pf_data <= '0;
      pf_full <= 1'b0;
    end else begin
      cur_data <= cur_data_d;
      cur_cnt <= cur_cnt_d;
      pf_full <= (pf_full && !pf_take) || accept;
      pf_data <= accept ? s_data : pf_data;
    end
  end
endmodule

// File: rtl/bin_unpack.sv
// bin_unpack: 1bpp packed bytes to RGB888 pixels; BIN_UNPACK_COLOR_EN adds fg_color/bg_color ports
module bin_unpack
  import bin_pkg::*;
#(
  parameter int H_ACTIVE = 1280
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BIN_UNPACK_COLOR_EN
  input  logic [PIX_W-1:0] fg_color,
  input  logic [PIX_W-1:0] bg_color,
`endif
  input  logic             line_start,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  input  logic             pix_req,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic             underflow
);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
  logic [PIX_W-1:0] fg, bg;
`ifdef BIN_UNPACK_COLOR_EN
  assign fg = fg_color;
  assign bg = bg_color;
`else
  assign fg = RGB_WHITE;
  assign bg = RGB_BLACK;
`endif
  state_t state, state_d, v_state;
  logic [7:0] cur_data, pf_data, v_data, a_data, cur_data_d;
  logic [3:0] cur_cnt, v_cnt, a_cnt, cur_cnt_d;
  logic [CNT_W-1:0] pix_cnt, v_pix;
  logic pf_full, v_pfull, pf_take, take, under, pix_end, need_load;
  bin_unpack_buf u_buf (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .pf_take(pf_take),
    .cur_data_d(cur_data_d),
    .cur_cnt_d(cur_cnt_d),
    .cur_data(cur_data),
    .cur_cnt(cur_cnt),
    .pf_data(pf_data),
    .pf_full(pf_full)
  );
  // v_* is the view after line_start has restarted the line, so a coincident pix_req sees the new state
  always_comb begin
    v_state = line_start ? (pf_full ? S_RUN : S_EMPTY) : state;
    v_data = line_start ? pf_data : cur_data;
    v_cnt = line_start ? (pf_full ? 4'd8 : 4'd0) : cur_cnt;
    v_pfull = pf_full && !line_start;
    v_pix = line_start ? '0 : pix_cnt;
    take = pix_req && (v_state == S_RUN);
    under = pix_req && (v_state == S_EMPTY);
    pix_end = pix_req && (v_state != S_PAD) && (v_pix == H_LAST);
    a_data = take ? {v_data[6:0], 1'b0} : v_data;
    a_cnt = take ? v_cnt - 4'd1 : v_cnt;
    need_load = !pix_end && v_pfull && ((v_state == S_EMPTY) || (v_state == S_RUN && a_cnt == 4'd0));
    state_d = pix_end ? S_PAD : need_load ? S_RUN : (v_state == S_RUN && a_cnt == 4'd0) ? S_EMPTY : v_state;
    cur_data_d = need_load ? pf_data : a_data;
    cur_cnt_d = pix_end ? 4'd0 : need_load ? 4'd8 : a_cnt;
    pf_take = (line_start && pf_full) || need_load;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
      pix_cnt <= '0;
      pix_valid <= 1'b0;
      pix_data <= RGB_BLACK;
      underflow <= 1'b0;
    end else begin
      state <= state_d;
      pix_cnt <= v_pix + CNT_W'(pix_req && (v_state != S_PAD));
      pix_valid <= pix_req;
      pix_data <= (take && v_data[7]) ? fg : bg;
      underflow <= (underflow && !line_start) || under;
    end
  end
endmodule
